// File: rtl/pc_redirect_unit_if.sv
// Branch-resolution / fetch-redirect bundle between the ID stage, the hazard unit
// and the PC redirect unit.
interface pc_redirect_unit_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic [1:0]        br_kind;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_imm;
  logic [ADDR_W-1:0] br_reg;
  logic [ADDR_W-1:0] pc_out;
  logic              if_valid;
  logic              flush_ifid;
  logic              link_we;
  logic [ADDR_W-1:0] link_data;
  logic              misalign;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stall, br_valid, br_taken, br_kind, br_pc, br_imm, br_reg,
    input  pc_out, if_valid, flush_ifid, link_we, link_data, misalign, redirect_cnt
  );

  modport slave (
    input  stall, br_valid, br_taken, br_kind, br_pc, br_imm, br_reg,
    output pc_out, if_valid, flush_ifid, link_we, link_data, misalign, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, taken-branch redirect with one-slot
// squash, BL link write, BR misalignment flag and a taken-redirect counter.
module pc_redirect_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input logic               clk,
  input logic               reset_n,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0]        KIND_REL = 2'b00;
  localparam logic [1:0]        KIND_BL  = 2'b01;
  localparam logic [1:0]        KIND_BR  = 2'b10;
  localparam logic [1:0]        KIND_RSV = 2'b11;
  localparam logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              misalign_r;
  logic              redirect_s;
  logic              is_bl_s;
  logic              br_unaligned_s;
  logic [ADDR_W-1:0] rel_target_s;
  logic [ADDR_W-1:0] reg_target_s;
  logic [ADDR_W-1:0] target_s;

  // Redirect qualification; && keeps an unknown br_taken from leaking when br_valid=0.
  always_comb begin
    redirect_s     = (state_r == ST_RUN) && bus.br_valid && bus.br_taken
                     && (bus.br_kind != KIND_RSV);
    is_bl_s        = redirect_s && (bus.br_kind == KIND_BL);
    br_unaligned_s = redirect_s && (bus.br_kind == KIND_BR)
                     && (bus.br_reg[1:0] != 2'b00);
  end

  // Branch target: word-scaled PC-relative offset, or register with low bits cleared.
  always_comb begin
    rel_target_s = bus.br_pc + {bus.br_imm[ADDR_W-3:0], 2'b00};
    reg_target_s = {bus.br_reg[ADDR_W-1:2], 2'b00};
    if (bus.br_kind == KIND_BR) begin
      target_s = reg_target_s;
    end else begin
      target_s = rel_target_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a redirect beats stall; BOOT always advances.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.stall) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Next fetch address selection.
  always_comb begin
    pc_nxt_s = pc_r;
    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (bus.stall) begin
      pc_nxt_s = pc_r;
    end else if (state_r == ST_BOOT) begin
      pc_nxt_s = pc_r;
    end else begin
      pc_nxt_s = pc_r + PC_STEP;
    end
  end

  // PC, redirect counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r       <= RESET_PC;
      cnt_r      <= '0;
      misalign_r <= 1'b0;
    end else begin
      pc_r <= pc_nxt_s;
      if (redirect_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (br_unaligned_s) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
    end
  end

  // FSM outputs; flush and link act in the resolving cycle.
  always_comb begin
    bus.pc_out       = pc_r;
    bus.redirect_cnt = cnt_r;
    bus.misalign     = misalign_r;
    bus.flush_ifid   = redirect_s;
    bus.link_we      = is_bl_s;
    bus.if_valid     = 1'b0;
    case (state_r)
      ST_RUN:   bus.if_valid = 1'b1;
      ST_FLUSH: bus.if_valid = 1'b1;
      default:  bus.if_valid = 1'b0;
    endcase
    if (is_bl_s) begin
      bus.link_data = bus.br_pc + PC_STEP;
    end else begin
      bus.link_data = '0;
    end
  end

endmodule
